// File: rtl/ita_step_sequencer.sv
// ITA step sequencer: walks a layer's step list, issues one token per (outer, inner) tile under an
// outstanding-tile cap, and barriers between steps. Define ITA_SEQ_PERF_EN for perf counters.
module ita_step_sequencer #(
  parameter int unsigned H              = 1,
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned TileW          = 32,
  localparam int unsigned NHeadsW = (H + 1 > 1) ? $clog2(H + 1) : 1,
  localparam int unsigned HeadW   = (H > 1) ? $clog2(H) : 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [1:0]         layer_i,
  input  logic [NHeadsW-1:0] n_heads_i,
  input  logic [TileW-1:0]   tile_s_i,
  input  logic [TileW-1:0]   tile_e_i,
  input  logic [TileW-1:0]   tile_p_i,
  input  logic [TileW-1:0]   tile_f_i,
  output logic               issue_valid_o,
  input  logic               issue_ready_i,
  output logic [3:0]         step_o,
  output logic [HeadW-1:0]   head_o,
  output logic [TileW-1:0]   outer_o,
  output logic [TileW-1:0]   inner_o,
  output logic [2:0]         requant_idx_o,
  input  logic               tile_done_i,
  output logic               busy_o,
  output logic               done_o
`ifdef ITA_SEQ_PERF_EN
  ,
  output logic [31:0]        perf_busy_cycles_o,
  output logic [31:0]        perf_stall_cycles_o,
  output logic [31:0]        perf_drain_cycles_o
`endif
);

  localparam int unsigned OutW = $clog2(MaxOutstanding + 1);

  localparam logic [1:0] LayerAttention   = 2'd0;
  localparam logic [1:0] LayerFeedforward = 2'd1;
  localparam logic [1:0] LayerLinear      = 2'd2;
  localparam logic [1:0] LayerSingleAttn  = 2'd3;

  localparam logic [3:0] StepIdle   = 4'd0;
  localparam logic [3:0] StepQ      = 4'd1;
  localparam logic [3:0] StepK      = 4'd2;
  localparam logic [3:0] StepV      = 4'd3;
  localparam logic [3:0] StepQK     = 4'd4;
  localparam logic [3:0] StepAV     = 4'd5;
  localparam logic [3:0] StepOW     = 4'd6;
  localparam logic [3:0] StepF1     = 4'd7;
  localparam logic [3:0] StepF2     = 4'd8;
  localparam logic [3:0] StepMatMul = 4'd9;

  typedef enum logic [2:0] {StIdle, StNext, StIssue, StDrain, StFinish} state_e;

  state_e             state_q, state_d;
  logic [3:0]         step_q, step_d;
  logic [HeadW-1:0]   head_q, head_d;
  logic [TileW-1:0]   outer_q, outer_d;
  logic [TileW-1:0]   inner_q, inner_d;
  logic [OutW-1:0]    outst_q, outst_d;

  logic [1:0]         layer_q;
  logic [NHeadsW-1:0] n_heads_q;
  logic [TileW-1:0]   tile_s_q, tile_e_q, tile_p_q, tile_f_q;

  logic               cfg_load;
  logic               issue_valid;
  logic               xfer;
  logic               done_ok;
  logic [3:0]         nxt_step;
  logic [HeadW-1:0]   nxt_head;
  logic               nxt_none;
  logic               nxt_empty;
  logic [TileW-1:0]   cur_inner;
  logic [3:0]         step_m1;

  // Inner-dimension length of a step; the outer dimension is always s.
  function automatic logic [TileW-1:0] inner_len(input logic [3:0] step,
                                                 input logic [TileW-1:0] s,
                                                 input logic [TileW-1:0] e,
                                                 input logic [TileW-1:0] p,
                                                 input logic [TileW-1:0] f);
    case (step)
      StepQ, StepK, StepV, StepAV, StepMatMul: inner_len = p;
      StepQK:                                   inner_len = s;
      StepOW, StepF2:                           inner_len = e;
      StepF1:                                   inner_len = f;
      default:                                  inner_len = '0;
    endcase
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      layer_q   <= '0;
      n_heads_q <= '0;
      tile_s_q  <= '0;
      tile_e_q  <= '0;
      tile_p_q  <= '0;
      tile_f_q  <= '0;
    end else if (cfg_load) begin
      layer_q   <= layer_i;
      n_heads_q <= (n_heads_i > NHeadsW'(H)) ? NHeadsW'(H) : n_heads_i;
      tile_s_q  <= tile_s_i;
      tile_e_q  <= tile_e_i;
      tile_p_q  <= tile_p_i;
      tile_f_q  <= tile_f_i;
    end
  end

  // Successor of step_q in the layer's step list (step_q == Idle means "first step").
  always_comb begin
    nxt_step = step_q;
    nxt_head = head_q;
    nxt_none = 1'b0;
    if (step_q == StepIdle) begin
      nxt_head = '0;
      case (layer_q)
        LayerAttention: begin
          nxt_step = StepQ;
          nxt_none = (n_heads_q == '0);
        end
        LayerSingleAttn:  nxt_step = StepQ;
        LayerFeedforward: nxt_step = StepF1;
        LayerLinear:      nxt_step = StepMatMul;
        default:          nxt_none = 1'b1;
      endcase
    end else begin
      case (step_q)
        StepOW: begin
          if (layer_q == LayerAttention && (32'(head_q) + 32'd1) < 32'(n_heads_q)) begin
            nxt_step = StepQ;
            nxt_head = head_q + HeadW'(1);
          end else begin
            nxt_none = 1'b1;
          end
        end
        StepF2, StepMatMul: nxt_none = 1'b1;
        default:            nxt_step = step_q + 4'd1;
      endcase
    end
  end

  assign nxt_empty = (tile_s_q == '0) ||
                     (inner_len(nxt_step, tile_s_q, tile_e_q, tile_p_q, tile_f_q) == '0);
  assign cur_inner = inner_len(step_q, tile_s_q, tile_e_q, tile_p_q, tile_f_q);

  assign issue_valid = (state_q == StIssue) && (32'(outst_q) < MaxOutstanding);
  assign xfer        = issue_valid && issue_ready_i;
  assign done_ok     = tile_done_i && (outst_q != '0);

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    head_d   = head_q;
    outer_d  = outer_q;
    inner_d  = inner_q;
    outst_d  = outst_q;
    cfg_load = 1'b0;

    if (xfer && !done_ok) begin
      outst_d = outst_q + 1'b1;
    end else if (!xfer && done_ok) begin
      outst_d = outst_q - 1'b1;
    end

    case (state_q)
      StIdle: begin
        if (start_i) begin
          cfg_load = 1'b1;
          state_d  = StNext;
          step_d   = StepIdle;
          head_d   = '0;
          outer_d  = '0;
          inner_d  = '0;
        end
      end
      StNext: begin
        if (nxt_none) begin
          state_d = StFinish;
        end else begin
          step_d  = nxt_step;
          head_d  = nxt_head;
          outer_d = '0;
          inner_d = '0;
          // Empty steps stay in Next for one cycle and are skipped.
          if (!nxt_empty) begin
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        if (xfer) begin
          if (inner_q == cur_inner - 1'b1) begin
            if (outer_q == tile_s_q - 1'b1) begin
              state_d = StDrain;
            end else begin
              inner_d = '0;
              outer_d = outer_q + 1'b1;
            end
          end else begin
            inner_d = inner_q + 1'b1;
          end
        end
      end
      StDrain: begin
        if (outst_q == '0) begin
          state_d = StNext;
        end
      end
      StFinish: begin
        state_d = StIdle;
        step_d  = StepIdle;
        head_d  = '0;
        outer_d = '0;
        inner_d = '0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      step_q  <= StepIdle;
      head_q  <= '0;
      outer_q <= '0;
      inner_q <= '0;
      outst_q <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      head_q  <= head_d;
      outer_q <= outer_d;
      inner_q <= inner_d;
      outst_q <= outst_d;
    end
  end

  assign step_m1       = step_q - 4'd1;
  assign requant_idx_o = (step_q >= StepQ && step_q <= StepF2) ? step_m1[2:0] : 3'd0;
  assign issue_valid_o = issue_valid;
  assign step_o        = step_q;
  assign head_o        = head_q;
  assign outer_o       = outer_q;
  assign inner_o       = inner_q;
  assign busy_o        = (state_q != StIdle);
  assign done_o        = (state_q == StFinish);

`ifdef ITA_SEQ_PERF_EN
  logic [31:0] perf_busy_q, perf_stall_q, perf_drain_q;

  // Saturating counters; Idle is not counted, so values hold after done.
  always_ff @(posedge clk_i) begin
    if (rst_i || cfg_load) begin
      perf_busy_q  <= '0;
      perf_stall_q <= '0;
      perf_drain_q <= '0;
    end else begin
      if (state_q != StIdle && perf_busy_q != '1) begin
        perf_busy_q <= perf_busy_q + 32'd1;
      end
      if (issue_valid && !issue_ready_i && perf_stall_q != '1) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
      if (state_q == StDrain && perf_drain_q != '1) begin
        perf_drain_q <= perf_drain_q + 32'd1;
      end
    end
  end

  assign perf_busy_cycles_o  = perf_busy_q;
  assign perf_stall_cycles_o = perf_stall_q;
  assign perf_drain_cycles_o = perf_drain_q;
`endif

endmodule

// File: doc/ita_step_sequencer.md
Name: ita_step_sequencer

Overview:
- Control-path scheduler in front of the ITA datapath.
- On a start pulse, walks the step sequence for the configured layer (Q,K,V,QK,AV,OW per head; F1,F2; or MatMul).
- Emits one tile-issue token per (outer, inner) tile with a valid/ready handshake, and tracks tile completions against an outstanding limit.
- Advances to the next step only after every tile of the current step has retired, giving a barrier between dependent steps.

Parameters:
- H, 1, number of attention heads (ita_package H)
- MaxOutstanding, 4, max issued-but-not-done tiles (≥1)
- TileW, 32, tile counter width (matches tile_t)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- start_i  in  1  single-cycle start pulse, sampled only in Idle
- layer_i  in  2  layer_e, sampled with start_i
- n_heads_i  in  idx_width(H+1)  heads to run for Attention, sampled with start_i
- tile_s_i, tile_e_i, tile_p_i, tile_f_i  in  TileW each  tile counts, sampled with start_i
- issue_valid_o  out  1  tile token valid
- issue_ready_i  in  1  datapath accepts token
- step_o  out  4  step_e of current token
- head_o  out  idx_width(H)  head index of current token
- outer_o, inner_o  out  TileW each  tile indices of current token
- requant_idx_o  out  3  requant constant select
- tile_done_i  in  1  one issued tile retired (pulse per tile)
- busy_o  out  1  sequence in progress
- done_o  out  1  one-cycle pulse when sequence completes

Behaviour:
- Reset values: all outputs 0, step_o=Idle, internal counters 0, outstanding=0. Reset mid-sequence aborts immediately; later tile_done_i pulses are ignored until the next start.
- Config registered at accepted start. start_i while busy_o=1 is ignored.
- Step list per layer:
  - Attention: for h in 0..n_heads-1: Q,K,V,QK,AV,OW
  - SingleAttention: Q,K,V,QK,AV,OW, one head, head_o=0
  - Feedforward: F1,F2
  - Linear: MatMul
- Per-step tile space (outer × inner):
  - Q,K,V: s×p
  - QK: s×s
  - AV: s×p
  - OW: s×e
  - F1: s×f
  - F2: s×e
  - MatMul: s×p
- Issue order: inner fastest, then outer.
- States:
  - IDLE: start_i moves to ISSUE with the first step.
  - ISSUE: token on issue_valid_o.
  - DRAIN: all tiles of the step issued; waits for outstanding==0.
  - NEXT: selects the next step, or goes to FINISH.
  - FINISH: done_o=1 for one cycle, then IDLE.
- issue_valid_o=1 in ISSUE iff outstanding<MaxOutstanding. Payload is stable while valid && !ready.
- A transfer (valid && ready) increments outstanding and advances inner/outer. The transfer of the last tile moves to DRAIN.
- tile_done_i decrements outstanding. A simultaneous transfer and done leaves it unchanged. tile_done_i at outstanding==0 is ignored, never wraps.
- Step with zero tiles (either dimension 0) is skipped: no tokens, no DRAIN wait, 1 cycle in NEXT.
- Attention with n_heads_i=0, or all steps empty: IDLE→NEXT→FINISH. done_o still pulses.
- n_heads_i>H is clamped to H.
- requant_idx_o = step-1 for Q..F2; 0 for MatMul and Idle.
- busy_o=1 from the cycle after accepted start through the FINISH cycle inclusive.
- Latency: first issue_valid_o is 2 cycles after start_i (register, then ISSUE). Step-to-step gap: 1 cycle after the DRAIN exit condition.

Optional Feature:
- ITA_SEQ_PERF_EN defined:
  - Adds outputs perf_busy_cycles_o (32), perf_stall_cycles_o (32, cycles with valid && !ready), and perf_drain_cycles_o (32, cycles in DRAIN).
  - Counters clear on accepted start and on reset, saturate at all-ones, and hold after done.
- Undefined: ports and counters absent, no logic.

Test Plan:
- Linear, s=2, p=3, ready tied 1, done_i returned 3 cycles after each issue: exactly 6 MatMul tokens, (outer,inner) (0,0),(0,1),(0,2),(1,0),(1,1),(1,2); requant_idx_o=0; done_o once.
- Feedforward, s=1, f=2, e=1, MaxOutstanding=4, done withheld 10 cycles: 2 F1 tokens, no F2 token until both dones arrive; then 1 F2 token.
- Attention n_heads=2, all tiles=1, immediate done: 12 tokens in step order Q,K,V,QK,AV,OW with head_o 0 then 1; requant_idx_o values 0..5 in step order.
- Backpressure: issue_ready_i=0 for 5 cycles with valid high: payload unchanged across all 5 cycles; MaxOutstanding=1 with done held off: valid deasserts after one transfer.
- Edge cases: tile_p=0 on Linear gives done_o 3 cycles after start with zero tokens; start_i while busy ignored; rst_i mid-ISSUE returns all outputs to 0 next cycle; spurious tile_done_i at outstanding 0 leaves outstanding at 0.
- ITA_SEQ_PERF_EN: 5-cycle ready stall gives perf_stall_cycles_o=5; counters reset on the next start.
